// File: rtl/rr_egress_scheduler.sv
// rtl/rr_egress_scheduler.sv - round-robin egress scheduler gated by a rate limiter
// Picks the next nonempty queue, asks the rate limiter, then dequeues or skips its group.
module rr_egress_scheduler #(
    parameter int QUEUE_ID_WIDTH    = 6,
    parameter int PACKET_SIZE_WIDTH = 11,
    parameter int QUEUE_ID_OFFSET   = 3,
    parameter int RL_TIMEOUT        = 15
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [2**QUEUE_ID_WIDTH-1:0]    nonempty_i,
    output logic [QUEUE_ID_WIDTH-1:0]       head_rd_id_o,
    input  logic [PACKET_SIZE_WIDTH-1:0]    head_plen_i,
    output logic [QUEUE_ID_WIDTH-1:0]       rl_id_o,
    output logic                            rl_id_valid_o,
    input  logic                            rl_ok_i,
    input  logic                            rl_ok_valid_i,
    input  logic [QUEUE_ID_WIDTH-1:0]       rl_next_id_i,
    output logic                            rl_take_o,
    output logic                            rl_drop_o,
    output logic [PACKET_SIZE_WIDTH-1:0]    rl_plen_o,
    output logic                            deq_valid_o,
    output logic [QUEUE_ID_WIDTH-1:0]       deq_id_o,
    input  logic                            deq_ready_i,
    output logic                            err_timeout_o
);

    localparam int NUM_QUEUES = 2**QUEUE_ID_WIDTH;
    localparam int CNT_W      = $clog2(RL_TIMEOUT + 1);
    localparam logic [QUEUE_ID_WIDTH-1:0] GRP_STEP = QUEUE_ID_WIDTH'(1) << QUEUE_ID_OFFSET;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REQ,
        S_WAIT,
        S_DEQ
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [QUEUE_ID_WIDTH-1:0]      r_ptr;
    logic [QUEUE_ID_WIDTH-1:0]      w_ptr_nxt;
    logic [CNT_W-1:0]               r_wait_cnt;
    logic [CNT_W-1:0]               w_wait_cnt_nxt;
    logic [PACKET_SIZE_WIDTH-1:0]   r_rl_plen;
    logic [PACKET_SIZE_WIDTH-1:0]   w_rl_plen_nxt;
    logic [QUEUE_ID_WIDTH-1:0]      r_deq_id;
    logic [QUEUE_ID_WIDTH-1:0]      w_deq_id_nxt;
    logic                           r_err_timeout;
    logic                           w_err_timeout_nxt;

    logic                           w_rl_id_valid;
    logic                           w_take;
    logic                           w_drop;
    logic                           w_deq_valid;

    logic [2*NUM_QUEUES-1:0]        w_dbl;
    logic [NUM_QUEUES-1:0]          w_rot;
    logic [QUEUE_ID_WIDTH-1:0]      w_offset;
    logic [QUEUE_ID_WIDTH-1:0]      w_found;
    logic [QUEUE_ID_WIDTH-1:0]      w_drop_ptr;
    logic                           w_any;
    logic                           w_cur_ne;
    logic                           w_timeout_hit;

    // Rotate the request vector so bit 0 is the current pointer; lowest set bit wins.
    assign w_dbl = {nonempty_i, nonempty_i};
    assign w_rot = NUM_QUEUES'(w_dbl >> r_ptr);

    always_comb begin
        w_offset = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_offset = QUEUE_ID_WIDTH'(i);
            end
        end
    end

    assign w_found       = r_ptr + w_offset;
    assign w_drop_ptr    = (r_ptr & ~(GRP_STEP - QUEUE_ID_WIDTH'(1))) + GRP_STEP;
    assign w_any         = |nonempty_i;
    assign w_cur_ne      = nonempty_i[r_ptr];
    assign w_timeout_hit = (r_wait_cnt == CNT_W'(RL_TIMEOUT - 1));

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_rl_plen_nxt     = r_rl_plen;
        w_deq_id_nxt      = r_deq_id;
        w_err_timeout_nxt = r_err_timeout;
        w_rl_id_valid     = 1'b0;
        w_take            = 1'b0;
        w_drop            = 1'b0;
        w_deq_valid       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_ptr_nxt   = w_found;
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_rl_plen_nxt = head_plen_i;
                w_state_nxt   = S_REQ;
            end
            S_REQ: begin
                w_rl_id_valid  = 1'b1;
                w_wait_cnt_nxt = '0;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                // A verdict in the last allowed cycle still beats the timeout.
                if (rl_ok_valid_i) begin
                    if (rl_ok_i && w_cur_ne) begin
                        w_take       = 1'b1;
                        w_deq_id_nxt = r_ptr;
                        w_ptr_nxt    = rl_next_id_i;
                        w_state_nxt  = S_DEQ;
                    end else begin
                        w_drop      = 1'b1;
                        w_ptr_nxt   = w_drop_ptr;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_timeout_hit) begin
                    w_err_timeout_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DEQ: begin
                w_deq_valid = 1'b1;
                if (deq_ready_i) begin
                    w_state_nxt = w_cur_ne ? S_LOOKUP : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_wait_cnt    <= '0;
            r_rl_plen     <= '0;
            r_deq_id      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_rl_plen     <= w_rl_plen_nxt;
            r_deq_id      <= w_deq_id_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    // Handshake outputs are masked by reset so no pulse escapes in the reset cycle.
    assign head_rd_id_o  = r_ptr;
    assign rl_id_o       = r_ptr;
    assign rl_id_valid_o = w_rl_id_valid & ~rst_i;
    assign rl_take_o     = w_take & ~rst_i;
    assign rl_drop_o     = w_drop & ~rst_i;
    assign rl_plen_o     = r_rl_plen;
    assign deq_valid_o   = w_deq_valid & ~rst_i;
    assign deq_id_o      = r_deq_id;
    assign err_timeout_o = r_err_timeout;

endmodule

// File: tb/tb_rr_egress_scheduler.sv
// tb/tb_rr_egress_scheduler.sv - directed self-checking bench for rr_egress_scheduler
module tb_rr_egress_scheduler;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [63:0] nonempty_i;
    logic [5:0]  head_rd_id_o;
    logic [10:0] head_plen_i;
    logic [5:0]  rl_id_o;
    logic        rl_id_valid_o;
    logic        rl_ok_i;
    logic        rl_ok_valid_i;
    logic [5:0]  rl_next_id_i;
    logic        rl_take_o;
    logic        rl_drop_o;
    logic [10:0] rl_plen_o;
    logic        deq_valid_o;
    logic [5:0]  deq_id_o;
    logic        deq_ready_i;
    logic        err_timeout_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_take   = 0;
    int n_drop   = 0;
    int n_hs     = 0;
    int t0, d0, h0;

    rr_egress_scheduler dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .nonempty_i    (nonempty_i),
        .head_rd_id_o  (head_rd_id_o),
        .head_plen_i   (head_plen_i),
        .rl_id_o       (rl_id_o),
        .rl_id_valid_o (rl_id_valid_o),
        .rl_ok_i       (rl_ok_i),
        .rl_ok_valid_i (rl_ok_valid_i),
        .rl_next_id_i  (rl_next_id_i),
        .rl_take_o     (rl_take_o),
        .rl_drop_o     (rl_drop_o),
        .rl_plen_o     (rl_plen_o),
        .deq_valid_o   (deq_valid_o),
        .deq_id_o      (deq_id_o),
        .deq_ready_i   (deq_ready_i),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk = ~clk;

    // Head-length table: queue 5 holds 100 bytes, every other queue 64+id.
    always_comb begin
        head_plen_i = (head_rd_id_o == 6'd5) ? 11'd100 : 11'(64 + head_rd_id_o);
    end

    always @(posedge clk) begin
        if (rl_take_o)                  n_take <= n_take + 1;
        if (rl_drop_o)                  n_drop <= n_drop + 1;
        if (deq_valid_o && deq_ready_i) n_hs   <= n_hs + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_i         = 1'b1;
        nonempty_i    = '0;
        rl_ok_i       = 1'b0;
        rl_ok_valid_i = 1'b0;
        rl_next_id_i  = '0;
        deq_ready_i   = 1'b0;
        tick();
        tick();
        check_eq(tag, {rl_id_valid_o, rl_take_o, rl_drop_o, deq_valid_o, err_timeout_o,
                       head_rd_id_o, rl_id_o, rl_plen_o, deq_id_o}, 64'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Scenario 1: single queue 5, granted
        do_reset("rst_init");
        t0 = n_take; h0 = n_hs;
        nonempty_i = 64'd1 << 5;
        tick();
        check_eq("s1_lookup_head", head_rd_id_o, 5);
        check_eq("s1_lookup_novalid", rl_id_valid_o, 0);
        tick();
        check_eq("s1_req_valid", rl_id_valid_o, 1);
        check_eq("s1_req_id", rl_id_o, 5);
        check_eq("s1_req_plen", rl_plen_o, 100);
        tick();
        check_eq("s1_wait_novalid", rl_id_valid_o, 0);
        rl_ok_valid_i = 1'b1; rl_ok_i = 1'b1; rl_next_id_i = 6'd5;
        #1;
        check_eq("s1_take_pulse", {rl_take_o, rl_drop_o}, 2'b10);
        check_eq("s1_take_plen", rl_plen_o, 100);
        tick();
        rl_ok_valid_i = 1'b0;
        check_eq("s1_deq_valid", deq_valid_o, 1);
        check_eq("s1_deq_id", deq_id_o, 5);
        check_eq("s1_take_once", {rl_take_o, 32'(n_take - t0)}, 1);
        deq_ready_i = 1'b1; nonempty_i = '0;
        tick();
        deq_ready_i = 1'b0;
        check_eq("s1_deq_done", deq_valid_o, 0);
        check_eq("s1_hs_count", n_hs - h0, 1);

        // Scenario 2: queues 2 and 9, drop on 2 skips to group 1
        do_reset("rst_s1");
        nonempty_i = (64'd1 << 2) | (64'd1 << 9);
        tick();
        tick();
        check_eq("s2_req_id_first", {rl_id_valid_o, rl_id_o}, {1'b1, 6'd2});
        check_eq("s2_req_plen", rl_plen_o, 66);
        tick();
        rl_ok_valid_i = 1'b1; rl_ok_i = 1'b0;
        #1;
        check_eq("s2_drop_pulse", {rl_take_o, rl_drop_o}, 2'b01);
        tick();
        rl_ok_valid_i = 1'b0;
        check_eq("s2_ptr_after_drop", head_rd_id_o, 8);
        check_eq("s2_drop_one_cycle", rl_drop_o, 0);
        tick();
        tick();
        check_eq("s2_req_id_second", {rl_id_valid_o, rl_id_o}, {1'b1, 6'd9});

        // Scenario 3: queue 62, drop wraps pointer to 0
        do_reset("rst_s2");
        nonempty_i = 64'd1 << 62;
        tick();
        tick();
        check_eq("s3_req_id_first", {rl_id_valid_o, rl_id_o}, {1'b1, 6'd62});
        check_eq("s3_req_plen", rl_plen_o, 126);
        tick();
        rl_ok_valid_i = 1'b1; rl_ok_i = 1'b0;
        #1;
        check_eq("s3_drop_pulse", rl_drop_o, 1);
        tick();
        rl_ok_valid_i = 1'b0;
        check_eq("s3_ptr_wrap", head_rd_id_o, 0);
        tick();
        tick();
        check_eq("s3_req_id_second", {rl_id_valid_o, rl_id_o}, {1'b1, 6'd62});

        // Scenario 4: no verdict, timeout after 15 WAIT cycles
        do_reset("rst_s3");
        t0 = n_take; d0 = n_drop;
        nonempty_i = 64'd1 << 7;
        tick();
        tick();
        check_eq("s4_req_valid", rl_id_valid_o, 1);
        for (int i = 0; i < 15; i++) tick();
        check_eq("s4_err_not_early", err_timeout_o, 0);
        tick();
        check_eq("s4_err_set", err_timeout_o, 1);
        check_eq("s4_no_pulse", (n_take - t0) + (n_drop - d0), 0);
        check_eq("s4_idle_novalid", rl_id_valid_o, 0);
        tick();
        check_eq("s4_lookup_novalid", rl_id_valid_o, 0);
        tick();
        check_eq("s4_rereq", {rl_id_valid_o, rl_id_o}, {1'b1, 6'd7});
        for (int i = 0; i < 5; i++) tick();
        rl_ok_valid_i = 1'b1; rl_ok_i = 1'b0;
        #1;
        check_eq("s4_counter_restart", rl_drop_o, 1);
        tick();
        rl_ok_valid_i = 1'b0;
        check_eq("s4_err_sticky", err_timeout_o, 1);

        // Scenario 5: dequeue back-pressure, then re-lookup of same queue
        do_reset("rst_s4");
        h0 = n_hs;
        nonempty_i = 64'd1 << 3;
        tick();
        tick();
        tick();
        rl_ok_valid_i = 1'b1; rl_ok_i = 1'b1; rl_next_id_i = 6'd3;
        tick();
        rl_ok_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("s5_hold", {deq_valid_o, deq_id_o}, {1'b1, 6'd3});
            tick();
        end
        check_eq("s5_hold_last", {deq_valid_o, deq_id_o}, {1'b1, 6'd3});
        check_eq("s5_no_hs_yet", n_hs - h0, 0);
        deq_ready_i = 1'b1;
        tick();
        deq_ready_i = 1'b0;
        check_eq("s5_deq_done", deq_valid_o, 0);
        check_eq("s5_hs_once", n_hs - h0, 1);
        tick();
        check_eq("s5_relookup_req", {rl_id_valid_o, rl_id_o}, {1'b1, 6'd3});

        // Scenario 6a: bit cleared before verdict turns a grant into a drop
        do_reset("rst_s5");
        nonempty_i = 64'd1 << 4;
        tick();
        tick();
        nonempty_i = '0;
        tick();
        rl_ok_valid_i = 1'b1; rl_ok_i = 1'b1; rl_next_id_i = 6'd4;
        #1;
        check_eq("s6_drop_not_take", {rl_take_o, rl_drop_o}, 2'b01);
        tick();
        rl_ok_valid_i = 1'b0;
        check_eq("s6_no_deq", deq_valid_o, 0);
        check_eq("s6_ptr_next_grp", head_rd_id_o, 8);

        // Scenario 6b: reset pulsed while in DEQ
        do_reset("rst_s6a");
        nonempty_i = 64'd1 << 1;
        tick();
        tick();
        tick();
        rl_ok_valid_i = 1'b1; rl_ok_i = 1'b1; rl_next_id_i = 6'd1;
        tick();
        rl_ok_valid_i = 1'b0;
        check_eq("s6_in_deq", {deq_valid_o, deq_id_o}, {1'b1, 6'd1});
        h0 = n_hs;
        rst_i = 1'b1; deq_ready_i = 1'b1;
        tick();
        check_eq("s6_rst_in_deq", {rl_id_valid_o, rl_take_o, rl_drop_o, deq_valid_o, err_timeout_o,
                                   head_rd_id_o, rl_id_o, rl_plen_o, deq_id_o}, 64'd0);
        check_eq("s6_rst_no_hs", n_hs - h0, 0);
        rst_i = 1'b0; deq_ready_i = 1'b0; nonempty_i = '0;
        tick();
        check_eq("s6_after_rst_idle", {deq_valid_o, rl_id_valid_o}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_egress_scheduler.md
RR_EGRESS_SCHEDULER -- requirements
Module: rr_egress_scheduler

Interface
REQ-001 The block SHALL have parameter QUEUE_ID_WIDTH, default 6, meaning the width of a queue id; NUM_QUEUES = 2**QUEUE_ID_WIDTH.
REQ-002 The block SHALL have parameter PACKET_SIZE_WIDTH, default 11, meaning the width of a packet length in bytes.
REQ-003 The block SHALL have parameter QUEUE_ID_OFFSET, default 3, meaning the number of id LSBs sharing one rate-limiter entry; a group is 2**QUEUE_ID_OFFSET queues.
REQ-004 The block SHALL have parameter RL_TIMEOUT, default 15, meaning the maximum number of cycles spent in WAIT.
REQ-005 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous and active-high.
REQ-007 nonempty_i  in  NUM_QUEUES  bit n is high while queue n holds at least one packet.
REQ-008 head_rd_id_o  out  QUEUE_ID_WIDTH  id whose head packet length is requested.
REQ-009 head_plen_i  in  PACKET_SIZE_WIDTH  head length of head_rd_id_o, valid one cycle after the address.
REQ-010 rl_id_o / rl_id_valid_o  out  QUEUE_ID_WIDTH / 1  check request to the rate limiter.
REQ-011 rl_ok_i / rl_ok_valid_i / rl_next_id_i  in  1 / 1 / QUEUE_ID_WIDTH  rate-limiter verdict and suggested next id.
REQ-012 rl_take_o / rl_drop_o / rl_plen_o  out  1 / 1 / PACKET_SIZE_WIDTH  update interface to the rate limiter.
REQ-013 deq_valid_o / deq_id_o / deq_ready_i  out / out / in  1 / QUEUE_ID_WIDTH / 1  dequeue command to the queue manager, valid/ready.
REQ-014 err_timeout_o  out  1  sticky flag set when a rate-limiter verdict is not received in time.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOOKUP, REQ, WAIT and DEQ.
REQ-016 IDLE: if any nonempty_i bit is set, ptr SHALL be loaded with the first set bit at or after ptr, searching round-robin with wrap from NUM_QUEUES-1 to 0, and the FSM SHALL go to LOOKUP; otherwise the FSM SHALL stay in IDLE.
REQ-017 LOOKUP: head_rd_id_o SHALL equal ptr (head_rd_id_o SHALL equal ptr in every state); on exit, head_plen_i SHALL be registered into rl_plen_o and the FSM SHALL go to REQ.
REQ-018 REQ: rl_id_valid_o SHALL be high for exactly this one cycle with rl_id_o = ptr, and the FSM SHALL go to WAIT.
REQ-019 rl_id_valid_o SHALL never be high outside REQ.
REQ-020 rl_plen_o SHALL remain stable from REQ until the cycle after the take or drop pulse.
REQ-021 WAIT with rl_ok_valid_i high, rl_ok_i high and nonempty_i[ptr] high: rl_take_o SHALL pulse for one cycle, deq_id_o SHALL be loaded with ptr, ptr SHALL be loaded with rl_next_id_i, and the FSM SHALL go to DEQ.
REQ-022 WAIT with rl_ok_valid_i high and either rl_ok_i low or nonempty_i[ptr] low: rl_drop_o SHALL pulse for one cycle, ptr SHALL be loaded with (group(ptr)+1) << QUEUE_ID_OFFSET modulo NUM_QUEUES, and the FSM SHALL go to IDLE.
REQ-023 rl_take_o and rl_drop_o SHALL never be high in the same cycle.
REQ-024 Each SHALL be high only in the single WAIT-exit cycle.
REQ-025 A WAIT cycle counter SHALL reset on WAIT entry; if it reaches RL_TIMEOUT without rl_ok_valid_i, err_timeout_o SHALL be set, no take or drop SHALL be issued, and the FSM SHALL go to IDLE.
REQ-026 err_timeout_o SHALL be cleared only by reset.
REQ-027 DEQ: deq_valid_o SHALL be high and deq_id_o SHALL be held stable until deq_ready_i is sampled high; then the FSM SHALL go to LOOKUP if nonempty_i[ptr] is high, else to IDLE.
REQ-028 deq_ready_i SHALL be ignored outside DEQ.
REQ-029 If deq_valid_o and deq_ready_i are high in the same cycle, exactly one dequeue SHALL be counted.
REQ-030 Pointer arithmetic SHALL be modulo NUM_QUEUES, so the wrap from the last group goes to queue 0.
REQ-031 Latency from IDLE with a nonempty queue to rl_id_valid_o SHALL be 2 cycles.
REQ-032 Latency from rl_ok_valid_i (granted) to deq_valid_o SHALL be 1 cycle.
REQ-033 A nonempty_i bit changing while the FSM is in LOOKUP, REQ or WAIT SHALL affect only the WAIT decision (REQ-021/022) and SHALL not abort the sequence.

Reset
REQ-034 While rst_i is high at a clock edge: state SHALL become IDLE, ptr and the WAIT counter SHALL become 0, and rl_id_valid_o, rl_take_o, rl_drop_o, deq_valid_o and err_timeout_o SHALL become 0.
REQ-035 Under the same reset: rl_id_o, rl_plen_o, deq_id_o and head_rd_id_o SHALL become 0.
REQ-036 Reset asserted mid-operation (any state) SHALL take effect in the same cycle, with no take, drop or deq pulse issued afterwards.

Verification
REQ-037 Scenario 1: nonempty_i = only bit 5, head_plen 100, ok = 1, next_id = 5 -> rl_id_o = 5 two cycles after leaving IDLE, one take with rl_plen_o = 100, then deq_id_o = 5 until ready.
REQ-038 Scenario 2: nonempty bits 2 and 9, verdict ok = 0 on queue 2 -> drop pulse, ptr becomes 8, next request is rl_id_o = 9.
REQ-039 Scenario 3: only bit 62 set with ptr at 62, verdict is a drop -> ptr becomes 0, then wraps back to 62; request ids are 62, then 62.
REQ-040 Scenario 4: rl_ok_valid_i held low -> after 15 WAIT cycles err_timeout_o = 1, the FSM is in IDLE, and no take or drop pulse occurred.
REQ-041 Scenario 5: deq_ready_i low for 4 cycles -> deq_valid_o stays high with deq_id_o stable; exactly one handshake occurs.
REQ-042 Scenario 6: nonempty bit cleared during WAIT while ok = 1 -> drop, not take; separately, rst_i pulsed in DEQ -> all outputs 0 on the next cycle.
